// File: rtl/hazard_pkg.sv
// Shared types and limits for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MUL_BUSY   = 2'd2,
    MEM_WAIT   = 2'd3
  } hazState_e;

  localparam int MAX_LOAD_LAT = 4;
  localparam int MAX_MUL_LAT  = 16;
  localparam int CNT_BITS     = 4;

  typedef logic [CNT_BITS-1:0] hazCnt_t;

  // Forces a latency parameter into its legal window so the down-counter
  // preload can never underflow or overflow.
  function automatic int latClamp(input int lat, input int minLat, input int maxLat);
    int clamped;
    clamped = lat;
    if (clamped < minLat) clamped = minLat;
    if (clamped > maxLat) clamped = maxLat;
    return clamped;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master = pipeline (drives stage status, consumes controls),
// slave  = hazard controller.
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_mem_read;
  logic              ex_mul_start;
  logic              ex_branch_taken;
  logic              mem_req;
  logic              dmem_ready;

  logic              pc_wr;
  logic              ifid_wr;
  logic              idex_wr;
  logic              exmem_wr;
  logic              memwb_wr;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              exmem_bubble;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
    output ex_valid, ex_rt, ex_mem_read, ex_mul_start, ex_branch_taken,
    output mem_req, dmem_ready,
    input  pc_wr, ifid_wr, idex_wr, exmem_wr, memwb_wr,
    input  ifid_flush, idex_bubble, exmem_bubble, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  ex_valid, ex_rt, ex_mem_read, ex_mul_start, ex_branch_taken,
    input  mem_req, dmem_ready,
    output pc_wr, ifid_wr, idex_wr, exmem_wr, memwb_wr,
    output ifid_flush, idex_bubble, exmem_bubble, stall_cycles
  );

endinterface

// File: rtl/hazard_match.sv
// One source-register comparator against the load destination in EX.
// Register 0 is hard-wired to zero, so it can never create a dependency.
module hazard_match #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] srcReg,
  input  logic              srcUsed,
  input  logic [REG_AW-1:0] dstReg,
  input  logic              dstLoad,
  output logic              hit
);

  assign hit = dstLoad & srcUsed & (dstReg != '0) & (dstReg == srcReg);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, multi-cycle EX occupancy,
// data-memory wait freezing, taken-branch flush and a stall-cycle counter.
// Outputs are a pure decode of (state, cnt, inputs).
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_ctrl_unit_if.slave bus
);

  localparam int LoadLatC = latClamp(LOAD_LAT, 1, MAX_LOAD_LAT);
  localparam int MulLatC  = latClamp(MUL_LAT, 2, MAX_MUL_LAT);

  // Hit cycle covers one stall cycle; LOAD_STALL covers cnt+1 more.
  localparam hazCnt_t LoadInit = hazCnt_t'((LoadLatC > 1) ? LoadLatC - 2 : 0);
  // Start cycle is the first frozen cycle; MUL_BUSY covers the remaining
  // MUL_LAT-2, so the front end is frozen MUL_LAT-1 cycles in total.
  localparam hazCnt_t MulInit  = hazCnt_t'(MulLatC - 2);
  localparam hazCnt_t CntOne   = hazCnt_t'(1);

  hazState_e         stateReg, stateNext;
  hazState_e         savedReg, savedNext;
  hazState_e         curState;
  hazCnt_t           cntReg, cntNext;
  logic [CNT_W-1:0]  stallReg, stallNext;

  logic [REG_AW-1:0] srcRegs [2];
  logic [1:0]        srcUsed;
  logic [1:0]        srcHit;
  logic              dstLoad;
  logic              loadUse;
  logic              memWait;
  logic              mulStart;

  logic pcWr, ifidWr, idexWr, exmemWr, memwbWr;
  logic ifidFlush, idexBubble, exmemBubble;

  assign srcRegs[0] = bus.id_rs;
  assign srcRegs[1] = bus.id_rt;
  assign srcUsed    = {bus.id_uses_rt, bus.id_uses_rs};
  assign dstLoad    = bus.ex_valid & bus.ex_mem_read;

  for (genvar gi = 0; gi < 2; gi++) begin : gMatch
    hazard_match #(.REG_AW(REG_AW)) uMatch (
      .srcReg  (srcRegs[gi]),
      .srcUsed (srcUsed[gi]),
      .dstReg  (bus.ex_rt),
      .dstLoad (dstLoad),
      .hit     (srcHit[gi])
    );
  end

  assign loadUse  = |srcHit;
  assign memWait  = bus.mem_req & ~bus.dmem_ready;
  assign mulStart = bus.ex_mul_start & bus.ex_valid;

  // Next-state and control decode; priority: mem wait, MUL_BUSY, branch,
  // LOAD_STALL, new load-use hit.
  always_comb begin
    // While frozen by memory, behave as the state that was interrupted.
    curState    = (stateReg == MEM_WAIT) ? savedReg : stateReg;
    stateNext   = curState;
    savedNext   = savedReg;
    cntNext     = cntReg;
    pcWr        = 1'b1;
    ifidWr      = 1'b1;
    idexWr      = 1'b1;
    exmemWr     = 1'b1;
    memwbWr     = 1'b1;
    ifidFlush   = 1'b0;
    idexBubble  = 1'b0;
    exmemBubble = 1'b0;

    if (memWait) begin
      pcWr      = 1'b0;
      ifidWr    = 1'b0;
      idexWr    = 1'b0;
      exmemWr   = 1'b0;
      memwbWr   = 1'b0;
      stateNext = MEM_WAIT;
      savedNext = curState;
    end else if (curState == MUL_BUSY) begin
      pcWr        = 1'b0;
      ifidWr      = 1'b0;
      idexWr      = 1'b0;
      exmemBubble = 1'b1;
      if (cntReg <= CntOne) begin
        stateNext = RUN;
        cntNext   = '0;
      end else begin
        cntNext = cntReg - CntOne;
      end
    end else if (bus.ex_branch_taken) begin
      // The ID instruction is wrong-path, so any hazard it raises is moot.
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
      stateNext  = RUN;
      cntNext    = '0;
    end else if (curState == LOAD_STALL) begin
      pcWr       = 1'b0;
      ifidWr     = 1'b0;
      idexBubble = 1'b1;
      if (cntReg == '0) begin
        stateNext = RUN;
      end else begin
        cntNext = cntReg - CntOne;
      end
    end else if (mulStart) begin
      pcWr        = 1'b0;
      ifidWr      = 1'b0;
      idexWr      = 1'b0;
      exmemBubble = 1'b1;
      if (MulInit != '0) begin
        stateNext = MUL_BUSY;
        cntNext   = MulInit;
      end
    end else if (loadUse) begin
      pcWr       = 1'b0;
      ifidWr     = 1'b0;
      idexBubble = 1'b1;
      if (LoadLatC > 1) begin
        stateNext = LOAD_STALL;
        cntNext   = LoadInit;
      end
    end
  end

  // Saturating count of front-end stall cycles.
  always_comb begin
    stallNext = stallReg;
    if (!pcWr && (stallReg != '1)) begin
      stallNext = stallReg + CNT_W'(1);
    end
  end

  // State, down-counter and performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= RUN;
      savedReg <= RUN;
      cntReg   <= '0;
      stallReg <= '0;
    end else begin
      stateReg <= stateNext;
      savedReg <= savedNext;
      cntReg   <= cntNext;
      stallReg <= stallNext;
    end
  end

  assign bus.pc_wr        = pcWr;
  assign bus.ifid_wr      = ifidWr;
  assign bus.idex_wr      = idexWr;
  assign bus.exmem_wr     = exmemWr;
  assign bus.memwb_wr     = memwbWr;
  assign bus.ifid_flush   = ifidFlush;
  assign bus.idex_bubble  = idexBubble;
  assign bus.exmem_bubble = exmemBubble;
  assign bus.stall_cycles = stallReg;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (LOAD_LAT=2, MUL_LAT=4, CNT_W=4).
// The driver pushes hand-computed expected controls per cycle; a monitor
// pops and compares them on the falling edge.
module tb_hazard_ctrl_unit;

  // Control vector order: pc, ifid, idex, exmem, memwb, flush, idexBub, exmemBub
  localparam logic [7:0] RUNV  = 8'b11111_000;
  localparam logic [7:0] LOADV = 8'b00111_010;
  localparam logic [7:0] MULV  = 8'b00011_001;
  localparam logic [7:0] MEMV  = 8'b00000_000;
  localparam logic [7:0] BRV   = 8'b11111_110;

  typedef struct {
    string      name;
    logic [7:0] out;
    logic [3:0] stall;
  } sbEntry_t;

  logic clk;
  logic rst_n;

  sbEntry_t   sbQ[$];
  logic [3:0] expStall;
  int         nCompared;
  int         nMismatched;

  hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(4)) hif ();

  hazard_ctrl_unit #(
    .REG_AW   (5),
    .LOAD_LAT (2),
    .MUL_LAT  (4),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One pipeline cycle: drive inputs just after the edge and queue the expectation.
  task automatic step(input string nm, input logic rst,
                      input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt,
                      input logic ev, input logic [4:0] ert, input logic mr,
                      input logic ms, input logic bt,
                      input logic mq, input logic dr,
                      input logic [7:0] expOut);
    sbEntry_t e;
    @(posedge clk);
    #1;
    rst_n               = ~rst;
    hif.id_rs           = rs;
    hif.id_uses_rs      = urs;
    hif.id_rt           = rt;
    hif.id_uses_rt      = urt;
    hif.ex_valid        = ev;
    hif.ex_rt           = ert;
    hif.ex_mem_read     = mr;
    hif.ex_mul_start    = ms;
    hif.ex_branch_taken = bt;
    hif.mem_req         = mq;
    hif.dmem_ready      = dr;
    if (rst) expStall = 4'd0;
    e.name  = nm;
    e.out   = expOut;
    e.stall = expStall;
    sbQ.push_back(e);
    // Counter model: one count per cycle that expects pc_wr=0, saturating.
    if (!rst && !expOut[7] && expStall != 4'hF) expStall = expStall + 4'd1;
  endtask

  task automatic idle(input string nm, input logic [7:0] expOut);
    step(nm, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, expOut);
  endtask

  // Monitor: compare every presented cycle against the head of the scoreboard.
  initial begin
    sbEntry_t   e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (sbQ.size() > 0) begin
        e   = sbQ.pop_front();
        act = {hif.pc_wr, hif.ifid_wr, hif.idex_wr, hif.exmem_wr, hif.memwb_wr,
               hif.ifid_flush, hif.idex_bubble, hif.exmem_bubble};
        nCompared++;
        if (act !== e.out) begin
          nMismatched++;
          $display("FAIL %s ctrl: got %b want %b", e.name, act, e.out);
        end
        nCompared++;
        if (hif.stall_cycles !== e.stall) begin
          nMismatched++;
          $display("FAIL %s stall_cycles: got %0d want %0d", e.name, hif.stall_cycles, e.stall);
        end
        $display("txn %-12s ctrl=%b stall=%0d", e.name, act, hif.stall_cycles);
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    expStall    = 4'd0;
    rst_n       = 1'b0;
    hif.id_rs = '0; hif.id_rt = '0; hif.id_uses_rs = 1'b0; hif.id_uses_rt = 1'b0;
    hif.ex_valid = 1'b0; hif.ex_rt = '0; hif.ex_mem_read = 1'b0;
    hif.ex_mul_start = 1'b0; hif.ex_branch_taken = 1'b0;
    hif.mem_req = 1'b0; hif.dmem_ready = 1'b1;

    //   name          rst   rs   urs  rt   urt  ev   ert  mr   ms   bt   mq   dr   expect
    step("reset",      1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RUNV);
    idle("idle",       RUNV);

    // Load-use on rs: exactly two stall cycles.
    step("ld_rs_hit",  1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LOADV);
    step("ld_rs_stl",  1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LOADV);
    idle("ld_rs_done", RUNV);

    // Register 0 and unused source never hazard; bubble in EX never hazards.
    step("ld_r0",      1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, RUNV);
    step("ld_nouse",   1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, RUNV);
    step("ld_noval",   1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, RUNV);

    // Load-use through rt.
    step("ld_rt_hit",  1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LOADV);
    step("ld_rt_stl",  1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LOADV);
    idle("ld_rt_done", RUNV);

    // Multi-cycle op: three frozen cycles, then RUN.
    step("mul_start",  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, MULV);
    step("mul_busy1",  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, MULV);
    step("mul_busy2",  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, MULV);
    idle("mul_done",   RUNV);

    // Multi-cycle op with two memory wait cycles in the middle: five frozen.
    step("mw_start",   1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, MULV);
    step("mw_busy1",   1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, MULV);
    step("mw_wait1",   1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, MEMV);
    step("mw_wait2",   1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, MEMV);
    step("mw_busy2",   1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, MULV);
    idle("mw_done",    RUNV);

    // Branch beats a simultaneous load-use hit; no stall counted.
    step("br_ld",      1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, BRV);
    idle("br_ld_next", RUNV);
    step("br_only",    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BRV);

    // Memory wait from RUN, then long enough to saturate the 4-bit counter.
    step("mem_wait",   1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, MEMV);
    step("mem_ready",  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, RUNV);
    for (int i = 0; i < 7; i++) begin
      step($sformatf("sat_%0d", i), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, MEMV);
    end
    idle("sat_hold",   RUNV);

    // Reset in the middle of a load stall abandons it at once.
    step("rs_hit",     1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LOADV);
    step("rs_assert",  1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RUNV);
    idle("rs_release", RUNV);
    step("rs_hit2",    1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LOADV);
    step("rs_stl2",    1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LOADV);
    idle("rs_done",    RUNV);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 4 && sbQ.size() != 0; i++) @(negedge clk);
    #1;
    if (sbQ.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("FAIL drain: %0d entries left, want 0", sbQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage CPU, sitting beside the ID stage and driving every pipeline-register write enable plus the bubble/flush controls. It generalises load-use detection to a configurable load-to-use latency and register width. It adds multi-cycle EX-operation (mul/div) occupancy, data-memory wait-state freezing, taken-branch flushing, and a saturating stall-cycle performance counter. All stall sequencing is held in a small FSM with a down-counter.

## Interface
- REG_AW, 5: register-address width.
- LOAD_LAT, 1: load-use stall cycles, legal 1..4.
- MUL_LAT, 4: EX occupancy of a multi-cycle op in cycles, legal 2..16.
- CNT_W, 16: width of the stall performance counter.

- clk  in  1: single clock; all state on rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- id_rs, id_rt  in  REG_AW: source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1: the ID instruction actually reads rs/rt.
- ex_valid  in  1: EX holds a real (non-bubble) instruction.
- ex_rt  in  REG_AW: load destination register in EX.
- ex_mem_read  in  1: EX instruction is a load.
- ex_mul_start  in  1: EX instruction is a multi-cycle op.
- ex_branch_taken  in  1: branch resolved taken in EX.
- mem_req  in  1: MEM stage is accessing data memory.
- dmem_ready  in  1: data memory completes this cycle.
- pc_wr, ifid_wr, idex_wr, exmem_wr, memwb_wr  out  1: pipeline-register write enables.
- ifid_flush  out  1: load NOP into IF/ID.
- idex_bubble  out  1: zero control fields entering ID/EX; the hazCtrl successor.
- exmem_bubble  out  1: zero control fields entering EX/MEM.
- stall_cycles  out  CNT_W: saturating count of cycles with pc_wr=0.

## Operation
- FSM states: RUN, LOAD_STALL, MUL_BUSY, MEM_WAIT. Down-counter cnt is 4 bits.
- Load-use hit: ex_valid & ex_mem_read & ex_rt!=0 & ((id_uses_rs & ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)). Register 0 never hazards.
- Priority per cycle, highest first: mem wait, MUL_BUSY, branch flush, LOAD_STALL, load-use hit.
- Mem wait: mem_req & !dmem_ready, from any state.
  - All five *_wr=0, no bubbles.
  - State and cnt are held; the FSM enters MEM_WAIT and returns to the saved state when dmem_ready rises.
- RUN, no event: all *_wr=1; flush and bubbles 0.
- Branch: ex_branch_taken in RUN gives ifid_flush=1 and idex_bubble=1, all *_wr=1, no stall.
  - Branch wins over a simultaneous load-use hit, because the ID instruction is wrong-path.
- Load-use hit in RUN: pc_wr=0, ifid_wr=0, idex_bubble=1 this cycle.
  - If LOAD_LAT>1: go to LOAD_STALL with cnt=LOAD_LAT-2.
- LOAD_STALL: same outputs as the hit cycle. cnt decrements each cycle; at cnt==0 return to RUN.
- ex_mul_start & ex_valid in RUN: go to MUL_BUSY with cnt=MUL_LAT-2.
  - Outputs in the start cycle and in MUL_BUSY: pc_wr=ifid_wr=idex_wr=0, exmem_bubble=1, exmem_wr=memwb_wr=1.
  - Leave MUL_BUSY at cnt==0; the next cycle is normal RUN, in which the result advances.
- stall_cycles: +1 on every cycle with pc_wr=0; saturates at all-ones and never wraps.

## Timing
- Outputs are combinational from state, cnt and inputs; no output latency.
- State, cnt and stall_cycles update on the rising clk edge.
- Stall lengths for an isolated event:
  - load-use: exactly LOAD_LAT cycles;
  - mul/div: exactly MUL_LAT-1 frozen front-end cycles;
  - mem wait: as many cycles as dmem_ready is low.
- Reset (rst_n low, asynchronous):
  - state=RUN, cnt=0, stall_cycles=0;
  - outputs then follow the RUN decode.
  - Reset mid-stall abandons the stall immediately.
- The pipeline must hold ex_* and id_* stable while frozen, since stage registers are not written.
- Back-to-back events are detected in the first RUN cycle after the previous stall ends.

## Structure
- Shared package hazard_pkg: state enum, MAX_LOAD_LAT=4, MAX_MUL_LAT=16, counter width constant.
- Sub-module hazard_match: one REG_AW comparator with use-enable and register-0 masking, instantiated for rs and rt.
- FSM, counter and output decode live in hazard_ctrl_unit.

## Test plan
- LOAD_LAT=2:
  - Stimulus: load ex_rt=5, ID id_rs=5, id_uses_rs=1.
  - Response: pc_wr=ifid_wr=0 and idex_bubble=1 for exactly 2 cycles; stall_cycles=2.
- Load ex_rt=0 with id_rs=0: no stall. Same case with id_uses_rs=0: no stall.
- MUL_LAT=4, ex_mul_start:
  - Response: 3 cycles with idex_wr=0 and exmem_bubble=1, then RUN.
  - Drop dmem_ready for 2 cycles mid-busy: total front-end stall is 5, and cnt resumes correctly.
- ex_branch_taken together with a load-use hit: ifid_flush=1, idex_bubble=1, pc_wr=1, stall_cycles unchanged.
- Reset mid-LOAD_STALL:
  - Assert rst_n=0 asynchronously: outputs immediately show the RUN decode.
  - After release, the next hazard is timed from scratch.
- CNT_W=4 with 20 stall cycles: stall_cycles saturates at 15.
